// File: rtl/rdn_pkg.sv
// Shared types for the RDN memory arbiter: line format, FSM states and client identifiers.
package rdn_pkg;

  localparam int LINE_WORDS = 8;

  typedef logic [LINE_WORDS-1:0][63:0] line_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    WT  = 1'b0,
    IMG = 1'b1
  } client_t;

  function automatic client_t other_client(input client_t c);
    return (c == WT) ? IMG : WT;
  endfunction

endpackage

// File: rtl/rdn_rr_arb2.sv
// Two-way round-robin grant: combinational choice, last_grant advances only on i_update.
module rdn_rr_arb2
  import rdn_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_elig,
  input  logic       i_update,
  output logic       o_valid,
  output client_t    o_gnt
);

  client_t r_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= IMG;
    end else if (i_update) begin
      r_last <= o_gnt;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    o_valid = |i_elig;
    o_gnt   = WT;
    case (i_elig)
      2'b01:   o_gnt = WT;
      2'b10:   o_gnt = IMG;
      2'b11:   o_gnt = other_client(r_last);
      default: o_gnt = WT;
    endcase
  end

endmodule

// File: rtl/rdn_mem_arb.sv
// Shares one host memory read port between the RDN weight and image loaders,
// fetching sequential cache lines per client with one read outstanding at a time.
module rdn_mem_arb
  import rdn_pkg::*;
#(
  parameter int ADDR_W = 42
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_wt_base,
  input  logic [ADDR_W-1:0] i_img_base,
  input  logic              i_wt_req,
  input  logic              i_img_req,
  output logic              o_wt_ready,
  output logic              o_img_ready,
  output line_t             o_wt_data,
  output line_t             o_img_data,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_req_ack,
  input  logic              i_rd_resp_valid,
  input  line_t             i_rd_resp_data,
  output logic              o_busy,
  output logic              o_err
);

  arb_state_t        r_state, w_state_next;
  client_t           r_cur;
  logic [ADDR_W-1:0] r_wt_ptr, r_img_ptr, r_rd_addr;
  logic [1:0]        r_pend;
  logic              r_rd_req, r_wt_ready, r_img_ready, r_err;
  line_t             r_wt_data, r_img_data;

  logic              w_busy, w_start_ok, w_fire, w_accept, w_resp, w_gnt_valid;
  logic [1:0]        w_req, w_elig, w_clr;
  client_t           w_gnt;
  logic [ADDR_W-1:0] w_gnt_ptr;

  assign w_req      = {i_img_req, i_wt_req};
  assign w_elig     = r_pend | w_req;
  assign w_busy     = (r_state != IDLE) || (|r_pend);
  assign w_start_ok = i_start && !w_busy;
  // A start cycle reloads the pointers, so no grant is made from the stale ones.
  assign w_fire     = (r_state == IDLE) && w_gnt_valid && !w_start_ok;
  assign w_accept   = (r_state == ISSUE) && i_rd_req_ack;
  assign w_resp     = (r_state == WAIT) && i_rd_resp_valid;
  assign w_gnt_ptr  = (w_gnt == WT) ? r_wt_ptr : r_img_ptr;
  assign w_clr      = !w_fire ? 2'b00 : ((w_gnt == IMG) ? 2'b10 : 2'b01);

  rdn_rr_arb2 u_rr (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_elig   (w_elig),
    .i_update (w_fire),
    .o_valid  (w_gnt_valid),
    .o_gnt    (w_gnt)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_fire)   w_state_next = ISSUE;
      ISSUE:   if (w_accept) w_state_next = WAIT;
      WAIT:    if (w_resp)   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the ready pulses
  // rely on the default clear below being overridden later in the same block.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cur       <= WT;
      r_wt_ptr    <= '0;
      r_img_ptr   <= '0;
      r_pend      <= '0;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= '0;
      r_wt_data   <= '0;
      r_img_data  <= '0;
      r_wt_ready  <= 1'b0;
      r_img_ready <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wt_ready  <= 1'b0;
      r_img_ready <= 1'b0;
      r_err       <= r_err || (|(r_pend & w_req));

      if (w_start_ok) begin
        r_wt_ptr  <= i_wt_base;
        r_img_ptr <= i_img_base;
        r_pend    <= '0;
      end else begin
        r_pend    <= (r_pend | w_req) & ~w_clr;
      end

      if (w_fire) begin
        r_rd_req  <= 1'b1;
        r_rd_addr <= w_gnt_ptr;
        r_cur     <= w_gnt;
      end

      if (w_accept) begin
        r_rd_req <= 1'b0;
        if (r_cur == WT) r_wt_ptr  <= r_wt_ptr + 1'b1;
        else             r_img_ptr <= r_img_ptr + 1'b1;
      end

      if (w_resp) begin
        if (r_cur == WT) begin
          r_wt_data  <= i_rd_resp_data;
          r_wt_ready <= 1'b1;
        end else begin
          r_img_data  <= i_rd_resp_data;
          r_img_ready <= 1'b1;
        end
      end
    end
  end

  assign o_wt_ready  = r_wt_ready;
  assign o_img_ready = r_img_ready;
  assign o_wt_data   = r_wt_data;
  assign o_img_data  = r_img_data;
  assign o_rd_req    = r_rd_req;
  assign o_rd_addr   = r_rd_addr;
  assign o_busy      = w_busy;
  assign o_err       = r_err;

endmodule

// File: doc/rdn_mem_arb.md
Name: rdn_mem_arb

Overview:
- Shares the single host memory read port between the RDN weight loader and the RDN image loader.
- Each client issues a one-cycle line request. The block round-robin arbitrates, fetches the next sequential cache line for that client, and returns it with a one-cycle ready pulse.
- Per-client line pointers are loaded from base addresses on start, so neither loader carries address logic.

Parameters:
- ADDR_W, 42, cache-line address width.
- LINE_WORDS, 8, 64-bit words per line (fixed by the memory interface).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  load base addresses and clear pointers/pending
- wt_base  in  ADDR_W  first line address of the weight image
- img_base  in  ADDR_W  first line address of the image data
- wt_req  in  1  weight loader line request (pulse)
- img_req  in  1  image loader line request (pulse)
- wt_ready  out  1  wt_data updated this cycle (pulse)
- img_ready  out  1  img_data updated this cycle (pulse)
- wt_data  out  LINE_WORDSx64  last line delivered to weight loader
- img_data  out  LINE_WORDSx64  last line delivered to image loader
- rd_req  out  1  memory read request
- rd_addr  out  ADDR_W  memory read line address
- rd_req_ack  in  1  memory accepts request this cycle
- rd_resp_valid  in  1  read response present
- rd_resp_data  in  LINE_WORDSx64  read response line
- busy  out  1  FSM not IDLE or any request pending
- err  out  1  sticky: request received while same client already pending

Behaviour:
- Reset: FSM=IDLE; wt_ptr, img_ptr, rd_addr, wt_data, img_data = 0; rd_req, wt_ready, img_ready, err, pending bits = 0; last_grant=IMG, so WT wins the first tie.
- start: accepted only when busy=0. Sets wt_ptr<=wt_base and img_ptr<=img_base. Ignored when busy=1; no err is raised.
- Request capture: x_req sets pend_x at the clock edge.
  - x_req while pend_x=1 sets err. The request is not queued twice.
- Arbitration in IDLE: eligible = pend | req, using the same-cycle request.
  - Single eligible client: grant it.
  - Both eligible: grant the client other than last_grant.
  - At that edge: FSM->ISSUE, rd_req<=1, rd_addr<=granted ptr, last_grant<=granted, pend_granted<=0. The request of the granted client is consumed.
- ISSUE:
  - rd_req and rd_addr are held stable until a cycle with rd_req_ack=1.
  - At that edge: rd_req<=0, granted ptr<=ptr+1 (mod 2^ADDR_W), FSM->WAIT.
- WAIT:
  - On rd_resp_valid: granted data register <= rd_resp_data, granted ready<=1 for exactly one cycle, FSM->IDLE.
  - rd_resp_valid in IDLE or ISSUE is ignored.
- Latency: with ack=1 and response latency L after acceptance, x_ready rises L+2 cycles after the x_req edge.
- Exactly one outstanding read at a time.
- Data hold: x_data changes only on x_ready. It holds while the other client is served, so a loader may consume words over 8+ cycles.
- Requests arriving in ISSUE/WAIT, including from the client being served, set pending and are served after return to IDLE. The arbiter re-evaluates in the same IDLE cycle the ready pulse is seen.
- rst mid-transaction: returns to reset state immediately. A late rd_resp_valid afterwards is ignored (FSM in IDLE).
- Pointer wrap: all-ones + 1 -> 0, no flag.

Decomposition:
- rdn_pkg holds: LINE_WORDS; typedef line_t (LINE_WORDS x 64-bit array); enum arb_state_t {IDLE, ISSUE, WAIT}; enum client_t {WT, IMG}.
- Sub-module rdn_rr_arb2: 2-way round-robin grant with last_grant register. It is combinational grant plus an update enable.

Test Plan:
- Single request: start with wt_base=0x100, wt_req pulse, ack=1, resp 3 cycles after accept.
  - Expect rd_addr=0x100 and wt_ready after 5 cycles with wt_data=resp.
  - A second wt_req gives rd_addr=0x101.
- Simultaneous: wt_req and img_req in the same cycle (img_base=0x200) after reset.
  - Expect WT served first at 0x100, then IMG at 0x200.
  - Next simultaneous pair: WT served first again, since last_grant=IMG.
- Backpressure: rd_req_ack low for 4 cycles.
  - Expect rd_req and rd_addr stable all 4 cycles, pointer advanced only after the ack cycle.
- Data hold: deliver a WT line, then serve IMG.
  - Expect wt_data unchanged while img_ready pulses.
  - Expect wt_ready never high without an outstanding WT read.
- Errors and start: wt_req twice while pending -> err=1, only one WT read issued. start while busy -> pointers unchanged.
- Reset in WAIT: assert rst, then drive rd_resp_valid.
  - Expect no ready pulse, rd_req=0, all pointers 0, FSM idle (busy=0).
